// File: rtl/seg_display_sched_pkg.sv
// Shared types and BCD helpers for the score/message display scheduler.
package seg_display_sched_pkg;

  localparam logic [3:0] BCD_MAX = 4'd9;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SHOW = 1'b1
  } state_e;

  typedef struct packed {
    logic       ovf;
    logic [3:0] tens;
    logic [3:0] units;
  } bcd2_t;

  function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
    logic [3:0] r;
    if (d > BCD_MAX) r = BCD_MAX;
    else             r = d;
    return r;
  endfunction

  // One step of a two-digit BCD counter; clear wins over increment.
  function automatic bcd2_t bcd2_step(input logic [3:0] tens, input logic [3:0] units,
                                      input logic inc, input logic clr);
    bcd2_t r;
    r.ovf   = 1'b0;
    r.tens  = tens;
    r.units = units;
    if (clr) begin
      r.tens  = 4'd0;
      r.units = 4'd0;
    end else if (inc) begin
      if (units >= BCD_MAX) begin
        r.units = 4'd0;
        if (tens >= BCD_MAX) begin
          r.tens = 4'd0;
          r.ovf  = 1'b1;
        end else begin
          r.tens = tens + 4'd1;
        end
      end else begin
        r.units = units + 4'd1;
      end
    end else begin
      r.ovf = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/seg_display_sched_bcd_counter2.sv
// Two-digit BCD counter with wrap 99 -> 00 and a registered overflow pulse.
import seg_display_sched_pkg::*;

module bcd_counter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       clr,
  output logic [3:0] tens,
  output logic [3:0] units,
  output logic       ovf
);

  bcd2_t nxt_s;

  // Next count from the shared step function.
  always_comb begin
    nxt_s = bcd2_step(tens, units, inc, clr);
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tens  <= 4'd0;
      units <= 4'd0;
      ovf   <= 1'b0;
    end else begin
      tens  <= nxt_s.tens;
      units <= nxt_s.units;
      ovf   <= nxt_s.ovf;
    end
  end

endmodule

// File: rtl/seg_display_sched.sv
// Shares a two-digit 7-segment decoder between a BCD score counter and a
// one-shot message that borrows the display for HOLD_MS milliseconds.
import seg_display_sched_pkg::*;

module seg_display_sched #(
  parameter int CLK_HZ  = 12_000_000,
  parameter int HOLD_MS = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       score_inc,
  input  logic       score_clr,
  input  logic       req_valid,
  input  logic [7:0] req_data,
  output logic       req_ack,
  output logic [3:0] seg_data_1,
  output logic [3:0] seg_data_2,
  output logic       showing,
  output logic       score_ovf
);

  localparam int PRESC_DIV = CLK_HZ / 1000;
  localparam int PW = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
  localparam int HW = $clog2(HOLD_MS + 1);
  localparam logic [PW-1:0] PRESC_MAX = PW'(PRESC_DIV - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_MS);

  state_e        state_r, state_fsm_s, state_nxt_s;
  logic [PW-1:0] presc_r, presc_fsm_s, presc_nxt_s;
  logic [HW-1:0] hold_r, hold_fsm_s, hold_nxt_s, hold_inc_s;
  logic [3:0]    msg_tens_r, msg_units_r, msg_tens_nxt_s, msg_units_nxt_s;
  logic [3:0]    score_tens_s, score_units_s;
  logic [3:0]    seg1_nxt_s, seg2_nxt_s;
  logic          accept_s;
  bcd2_t         score_nxt_s;

  bcd_counter2 u_score (
    .clk   (clk),
    .rst   (rst),
    .inc   (score_inc),
    .clr   (score_clr),
    .tens  (score_tens_s),
    .units (score_units_s),
    .ovf   (score_ovf)
  );

  // FSM sequencing: millisecond prescaler and hold counter while showing.
  always_comb begin
    state_fsm_s = state_r;
    presc_fsm_s = presc_r;
    hold_fsm_s  = hold_r;
    accept_s    = 1'b0;
    hold_inc_s  = hold_r + HW'(1);
    case (state_r)
      ST_IDLE: begin
        if (req_valid) accept_s = 1'b1;
        else           state_fsm_s = ST_IDLE;
      end
      ST_SHOW: begin
        if (presc_r == PRESC_MAX) begin
          presc_fsm_s = '0;
          // A request waiting at the end of a message is taken without a score frame.
          if (hold_inc_s == HOLD_LAST) begin
            if (req_valid) accept_s = 1'b1;
            else           state_fsm_s = ST_IDLE;
          end else begin
            hold_fsm_s = hold_inc_s;
          end
        end else begin
          presc_fsm_s = presc_r + PW'(1);
        end
      end
      default: state_fsm_s = ST_IDLE;
    endcase
  end

  // Request acceptance overrides the sequencing and captures a clamped message.
  always_comb begin
    if (accept_s) begin
      state_nxt_s     = ST_SHOW;
      presc_nxt_s     = '0;
      hold_nxt_s      = '0;
      msg_tens_nxt_s  = bcd_clamp(req_data[7:4]);
      msg_units_nxt_s = bcd_clamp(req_data[3:0]);
    end else begin
      state_nxt_s     = state_fsm_s;
      presc_nxt_s     = presc_fsm_s;
      hold_nxt_s      = hold_fsm_s;
      msg_tens_nxt_s  = msg_tens_r;
      msg_units_nxt_s = msg_units_r;
    end
  end

  // Output mux looks at next-cycle state so score changes show one cycle after the pulse.
  always_comb begin
    score_nxt_s = bcd2_step(score_tens_s, score_units_s, score_inc, score_clr);
    if (state_nxt_s == ST_SHOW) begin
      seg1_nxt_s = msg_tens_nxt_s;
      seg2_nxt_s = msg_units_nxt_s;
    end else begin
      seg1_nxt_s = score_nxt_s.tens;
      seg2_nxt_s = score_nxt_s.units;
    end
  end

  // State, counters, message and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      presc_r     <= '0;
      hold_r      <= '0;
      msg_tens_r  <= 4'd0;
      msg_units_r <= 4'd0;
      req_ack     <= 1'b0;
      showing     <= 1'b0;
      seg_data_1  <= 4'd0;
      seg_data_2  <= 4'd0;
    end else begin
      state_r     <= state_nxt_s;
      presc_r     <= presc_nxt_s;
      hold_r      <= hold_nxt_s;
      msg_tens_r  <= msg_tens_nxt_s;
      msg_units_r <= msg_units_nxt_s;
      req_ack     <= accept_s;
      showing     <= (state_nxt_s == ST_SHOW);
      seg_data_1  <= seg1_nxt_s;
      seg_data_2  <= seg2_nxt_s;
    end
  end

endmodule

// File: tb/tb_seg_display_sched.sv
// Directed bench for seg_display_sched at 4 cycles/ms and a 3 ms (12-cycle) hold.
module tb_seg_display_sched;

  logic       clk;
  logic       rst;
  logic       score_inc;
  logic       score_clr;
  logic       req_valid;
  logic [7:0] req_data;
  logic       req_ack;
  logic [3:0] seg_data_1;
  logic [3:0] seg_data_2;
  logic       showing;
  logic       score_ovf;

  int checks = 0;
  int errors = 0;

  seg_display_sched #(.CLK_HZ(4000), .HOLD_MS(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .score_inc  (score_inc),
    .score_clr  (score_clr),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ack    (req_ack),
    .seg_data_1 (seg_data_1),
    .seg_data_2 (seg_data_2),
    .showing    (showing),
    .score_ovf  (score_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_inc(input int n);
    for (int i = 0; i < n; i++) begin
      score_inc = 1'b1;
      tick();
    end
    score_inc = 1'b0;
  endtask

  int show_cnt;
  int ack_cnt;
  int bad_digits;
  logic early_ack;
  logic gap;

  initial begin
    rst = 1'b1; score_inc = 1'b0; score_clr = 1'b0; req_valid = 1'b0; req_data = 8'h00;
    #12;
    check("rst_digits", {seg_data_1, seg_data_2}, 8'h00);
    check("rst_ack", req_ack, 1'b0);
    check("rst_showing", showing, 1'b0);
    check("rst_ovf", score_ovf, 1'b0);
    rst = 1'b0;
    tick();

    // 1: count to 12, then async reset mid-run
    pulse_inc(12);
    check("t1_digits", {seg_data_1, seg_data_2}, 8'h12);
    check("t1_showing", showing, 1'b0);
    rst = 1'b1;
    #1;
    check("t1_rst_digits", {seg_data_1, seg_data_2}, 8'h00);
    #1;
    rst = 1'b0;
    tick();

    // 2: wrap 99 -> 00 with one-cycle ovf; clr beats inc
    pulse_inc(99);
    check("t2_at99", {seg_data_1, seg_data_2}, 8'h99);
    check("t2_ovf_before", score_ovf, 1'b0);
    pulse_inc(1);
    check("t2_wrap", {seg_data_1, seg_data_2}, 8'h00);
    check("t2_ovf_pulse", score_ovf, 1'b1);
    tick();
    check("t2_ovf_single", score_ovf, 1'b0);
    pulse_inc(45);
    check("t2_at45", {seg_data_1, seg_data_2}, 8'h45);
    score_inc = 1'b1; score_clr = 1'b1;
    tick();
    score_inc = 1'b0; score_clr = 1'b0;
    check("t2_clr_digits", {seg_data_1, seg_data_2}, 8'h00);
    check("t2_clr_no_ovf", score_ovf, 1'b0);

    // 3: message 37 shown for exactly 12 cycles with a single ack
    req_valid = 1'b1; req_data = 8'h37;
    tick();
    req_valid = 1'b0; req_data = 8'h00;
    check("t3_ack", req_ack, 1'b1);
    check("t3_digits", {seg_data_1, seg_data_2}, 8'h37);
    show_cnt = 1; ack_cnt = 1; bad_digits = 0;
    for (int i = 0; i < 13; i++) begin
      tick();
      if (showing) show_cnt++;
      if (req_ack) ack_cnt++;
      if (showing && {seg_data_1, seg_data_2} != 8'h37) bad_digits++;
    end
    check("t3_show_cycles", show_cnt, 12);
    check("t3_ack_cycles", ack_cnt, 1);
    check("t3_msg_stable", bad_digits, 0);
    check("t3_score_back", {seg_data_1, seg_data_2}, 8'h00);

    // 4: clamp AF -> 99; score counted during SHOW appears afterwards
    pulse_inc(20);
    check("t4_at20", {seg_data_1, seg_data_2}, 8'h20);
    req_valid = 1'b1; req_data = 8'hAF;
    tick();
    req_valid = 1'b0;
    check("t4_clamp", {seg_data_1, seg_data_2}, 8'h99);
    pulse_inc(5);
    check("t4_hidden", {seg_data_1, seg_data_2}, 8'h99);
    repeat (6) tick();
    check("t4_last_show", showing, 1'b1);
    tick();
    check("t4_end_show", showing, 1'b0);
    check("t4_score25", {seg_data_1, seg_data_2}, 8'h25);

    // 5: request held mid-SHOW is acked back-to-back
    req_valid = 1'b1; req_data = 8'h12;
    tick();
    req_valid = 1'b0;
    repeat (3) tick();
    req_valid = 1'b1; req_data = 8'h56;
    early_ack = 1'b0; gap = 1'b0;
    for (int i = 4; i <= 12; i++) begin
      tick();
      if (i < 12) early_ack = early_ack | req_ack;
      if (!showing) gap = 1'b1;
    end
    req_valid = 1'b0;
    check("t5_no_early_ack", early_ack, 1'b0);
    check("t5_no_gap", gap, 1'b0);
    check("t5_ack", req_ack, 1'b1);
    check("t5_next_msg", {seg_data_1, seg_data_2}, 8'h56);
    repeat (12) tick();
    check("t5_done", showing, 1'b0);
    check("t5_score", {seg_data_1, seg_data_2}, 8'h25);

    // 6: reset during SHOW aborts, held request re-acked after release
    req_valid = 1'b1; req_data = 8'h88;
    tick();
    check("t6_ack", req_ack, 1'b1);
    tick();
    check("t6_held_no_ack", req_ack, 1'b0);
    repeat (5) tick();
    rst = 1'b1;
    #1;
    check("t6_rst_showing", showing, 1'b0);
    check("t6_rst_digits", {seg_data_1, seg_data_2}, 8'h00);
    #1;
    rst = 1'b0;
    tick();
    req_valid = 1'b0;
    check("t6_reack", req_ack, 1'b1);
    check("t6_reshow", {seg_data_1, seg_data_2}, 8'h88);
    repeat (12) tick();
    check("t6_score_cleared", {seg_data_1, seg_data_2}, 8'h00);
    check("t6_done", showing, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
